// File: rtl/accelerator_pkg.sv
// rtl/accelerator_pkg.sv - shared types and helpers for the vector accelerator
package accelerator_pkg;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_EXEC = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] instr;
  } apu_instr_t;

  // Register field positions inside the vector instruction word
  localparam int unsigned VD_LSB  = 7;
  localparam int unsigned VS1_LSB = 15;
  localparam int unsigned VS2_LSB = 20;

  // SEW encoding 3 is reserved; it steps like 32-bit elements
  function automatic logic [1:0] eff_sew(input logic [1:0] sew);
    return (sew == 2'd3) ? 2'd2 : sew;
  endfunction

endpackage

// File: rtl/vector_instr_fifo.sv
// rtl/vector_instr_fifo.sv - instruction queue between the APU port and the sequencer
module vector_instr_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type T = logic [31:0],
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          in_tvalid,
  output logic          in_tready,
  input  T              in_tdata,
  output logic          out_tvalid,
  input  logic          out_tready,
  output T              out_tdata,
  output logic [CW-1:0] count
);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Ready depends only on occupancy: a pop in the same cycle never frees a slot early
  assign in_tready  = (count_q != CW'(DEPTH));
  assign out_tvalid = (count_q != '0);
  assign out_tdata  = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign do_push    = in_tvalid & in_tready;
  assign do_pop     = out_tvalid & out_tready;

  // Storage, pointer and occupancy update; pointers wrap naturally at a power-of-two depth
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = in_tdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue registers, cleared asynchronously so a reset drops every pending entry
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vector_sequencer.sv
// rtl/vector_sequencer.sv - queues APU vector instructions and steps them across lane-sized cycles
module vector_sequencer
  import accelerator_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned VLMAX       = 16,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned NUM_VREGS   = 32,
  localparam int unsigned VL_W = $clog2(VLMAX + 1),
  localparam int unsigned CC_W = ($clog2(VLMAX / NUM_LANES) < 1) ? 1 : $clog2(VLMAX / NUM_LANES),
  localparam int unsigned AW   = $clog2(NUM_VREGS)
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 apu_req,
  output logic                 apu_gnt,
  input  logic [2:0][31:0]     apu_operands,
  output logic                 apu_rvalid,
  input  logic [VL_W-1:0]      vl,
  input  logic [1:0]           vsew,
  output logic [31:0]          instr_word,
  output logic [31:0]          scalar_operand1,
  output logic [31:0]          scalar_operand2,
  input  logic                 multi_cycle_instr,
  input  logic                 reduce_instr,
  output logic                 busy,
  output logic [CC_W-1:0]      cycle_count,
  output logic                 last_cycle,
  output logic [AW-1:0]        vs1_addr,
  output logic [AW-1:0]        vs2_addr,
  output logic [AW-1:0]        vd_addr,
  output logic [NUM_LANES-1:0] lane_mask
);

  localparam int unsigned LANE_SH = $clog2(NUM_LANES);
  localparam int unsigned QCW     = $clog2(QUEUE_DEPTH + 1);

  apu_instr_t     push_data, head;
  logic           fifo_ready, fifo_valid, push, pop;
  logic [QCW-1:0] fifo_count;

  seq_state_t      state_q, state_d;
  logic [CC_W-1:0] cycle_count_q, cycle_count_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic [1:0]      sew_q, sew_d;

  logic [CC_W-1:0]      max_cycle;
  logic [VL_W-1:0]      vl_m1, rem;
  logic [NUM_LANES-1:0] tail_mask;
  logic [AW-1:0]        stride_off;
  logic                 busy_i, last_i;

  assign push_data = '{op1: apu_operands[0], op2: apu_operands[1], instr: apu_operands[2]};
  assign apu_gnt   = fifo_ready;
  assign push      = apu_req & fifo_ready;
  assign busy_i    = (state_q == SEQ_EXEC);
  assign last_i    = busy_i && (cycle_count_q == max_cycle);
  assign pop       = last_i;

  vector_instr_fifo #(
    .DEPTH(QUEUE_DEPTH),
    .T    (apu_instr_t)
  ) u_fifo (
    .clk       (clk),
    .n_reset   (n_reset),
    .in_tvalid (push),
    .in_tready (fifo_ready),
    .in_tdata  (push_data),
    .out_tvalid(fifo_valid),
    .out_tready(pop),
    .out_tdata (head),
    .count     (fifo_count)
  );

  // Index of the final cycle and how many elements remain for it
  always_comb begin
    vl_m1     = vl_q - VL_W'(1);
    max_cycle = '0;
    if (multi_cycle_instr && (vl_q != '0)) begin
      max_cycle = CC_W'(vl_m1 >> LANE_SH);
    end
    rem = vl_q - (VL_W'(max_cycle) << LANE_SH);
  end

  // Write enables: full lanes mid-instruction, partial tail, lane 0 only for reductions
  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      tail_mask[i] = (rem > VL_W'(i));
    end
    lane_mask = '0;
    if (busy_i && (vl_q != '0)) begin
      if (reduce_instr) begin
        lane_mask = last_i ? NUM_LANES'(1) : '0;
      end else if (!last_i || !multi_cycle_instr) begin
        lane_mask = '1;
      end else begin
        lane_mask = tail_mask;
      end
    end
  end

  // Register addresses advance by one element group per cycle and wrap in the register file
  always_comb begin
    stride_off = AW'(cycle_count_q) << eff_sew(sew_q);
    vd_addr    = '0;
    vs1_addr   = '0;
    vs2_addr   = '0;
    if (busy_i) begin
      vs2_addr = head.instr[VS2_LSB +: AW] + stride_off;
      if (reduce_instr) begin
        vd_addr  = head.instr[VD_LSB +: AW];
        vs1_addr = head.instr[VS1_LSB +: AW];
      end else begin
        vd_addr  = head.instr[VD_LSB +: AW] + stride_off;
        vs1_addr = head.instr[VS1_LSB +: AW] + stride_off;
      end
    end
  end

  // Issue from the queue, step cycles, then chain the next entry or fall back to idle
  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    vl_d          = vl_q;
    sew_d         = sew_q;
    case (state_q)
      SEQ_IDLE: begin
        if (push || fifo_valid) begin
          state_d       = SEQ_EXEC;
          cycle_count_d = '0;
          vl_d          = vl;
          sew_d         = vsew;
        end
      end
      SEQ_EXEC: begin
        if (last_i) begin
          cycle_count_d = '0;
          if ((fifo_count > QCW'(1)) || push) begin
            vl_d  = vl;
            sew_d = vsew;
          end else begin
            state_d = SEQ_IDLE;
          end
        end else begin
          cycle_count_d = cycle_count_q + CC_W'(1);
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // Sequencer state; asynchronous reset abandons the running instruction without a response
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= SEQ_IDLE;
      cycle_count_q <= '0;
      vl_q          <= '0;
      sew_q         <= '0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      vl_q          <= vl_d;
      sew_q         <= sew_d;
    end
  end

  assign busy            = busy_i;
  assign last_cycle      = last_i;
  assign apu_rvalid      = last_i;
  assign cycle_count     = cycle_count_q;
  assign instr_word      = busy_i ? head.instr : '0;
  assign scalar_operand1 = busy_i ? head.op1   : '0;
  assign scalar_operand2 = busy_i ? head.op2   : '0;

endmodule

// File: doc/vector_sequencer.md
# vector_sequencer

Parametrised instruction sequencer for the vector accelerator. It accepts vector instructions from the APU interface into a small queue so the core is not stalled while a multi-cycle instruction runs. It steps the head instruction through ceil(vl/NUM_LANES) execution cycles, generating per-cycle register addresses and lane write masks. It returns apu_rvalid on completion and sits between the APU port and the combinational opcode decoder / PE array control.

## Interface
- NUM_LANES, 4: elements processed per cycle; power of two, 2..16.
- VLMAX, 16: maximum vl; multiple of NUM_LANES.
- QUEUE_DEPTH, 2: instruction queue entries; power of two, ≥2.
- NUM_VREGS, 32: vector register count; register width = 8·NUM_LANES bits.
- clk  in  1  clock.
- n_reset  in  1  reset, asynchronous, active-low.
- apu_req  in  1  instruction offered.
- apu_gnt  out  1  queue accepts this cycle.
- apu_operands  in  3×32  scalar op1, scalar op2, instruction word.
- apu_rvalid  out  1  one-cycle pulse on the last EXEC cycle of an instruction.
- vl  in  $clog2(VLMAX+1)  current vector length.
- vsew  in  2  current SEW (0=8b, 1=16b, 2=32b).
- instr_word, scalar_operand1, scalar_operand2  out  32 each  head-entry fields, for the decoder.
- multi_cycle_instr  in  1  from decoder, for the head instruction.
- reduce_instr  in  1  from decoder; holds vd/vs1 fixed and writes lane 0 only.
- busy  out  1  state==EXEC.
- cycle_count  out  $clog2(VLMAX/NUM_LANES) (min 1)  current EXEC cycle index.
- last_cycle  out  1  cycle_count==max_cycle.
- vs1_addr, vs2_addr, vd_addr  out  $clog2(NUM_VREGS) each  register addresses for this cycle.
- lane_mask  out  NUM_LANES  lanes whose result is written this cycle.

## Operation
- Queue: FIFO of {operands[0..2]}.
  - apu_gnt = !full. Push when apu_req & apu_gnt.
  - No bypass: when full, a same-cycle pop does not raise apu_gnt.
- States: IDLE, EXEC.
  - IDLE→EXEC when queue not empty. On entry, latch vl_q=vl and sew_q=vsew.
  - EXEC→EXEC (next entry, cycle_count=0, relatch vl/vsew) on last_cycle when the queue has another entry after the pop. This gives back-to-back issue with no bubble.
  - EXEC→IDLE on last_cycle when the queue empties.
- Pop happens on the last_cycle edge. Outputs present the head entry throughout EXEC.
- max_cycle:
  - multi_cycle_instr=1: (vl_q−1)/NUM_LANES. vl_q=0 gives 0.
  - multi_cycle_instr=0: 0.
- Address stride per cycle: (1<<sew_q) registers; sew_q=3 is treated as 2.
- vsX_addr = field + cycle_count·stride, modulo NUM_VREGS (wraps 31→0).
- reduce_instr: vd/vs1 fixed at the field value; vs2 still strides.
- lane_mask:
  - Non-reduce, non-last cycle: all ones.
  - Last cycle: lanes i < rem set, where rem = vl_q − max_cycle·NUM_LANES. rem==NUM_LANES gives all ones; vl_q=0 gives zero.
  - Reduce: zero except last cycle, which is 1 (lane 0), or zero if vl_q=0.
  - Single-cycle instructions: mask all ones when vl_q>0.
  - IDLE: zero.
- A vl/vsew change during EXEC (e.g. vsetvli writeback) does not affect the running instruction.

## Timing
- Reset values: queue empty, state IDLE, apu_gnt=1, apu_rvalid=0, busy=0, cycle_count=0, lane_mask=0, last_cycle=0, addresses=0, instr_word/scalars=0.
- Latency:
  - req accepted at cycle t into an empty, idle queue → EXEC cycle 0 at t+1.
  - apu_rvalid at t+1+max_cycle.
- Reset mid-EXEC: all state clears immediately (asynchronous). The in-flight instruction and queued entries are dropped with no rvalid.
- Push and pop in the same cycle: the occupancy count is unchanged.

## Structure
- Add to accelerator_pkg:
  - seq_state_t enum {SEQ_IDLE, SEQ_EXEC}.
  - apu_instr_t packed struct {op1, op2, instr}.
- Sub-module vector_instr_fifo, parametrised by DEPTH and element type, holding the queue; the sequencer itself stays flat.
- The existing opcode decoder consumes instr_word and drives multi_cycle_instr/reduce_instr combinationally.

## Test plan
- vl=16, vsew=0, vadd with vs1=4, vs2=8, vd=12 → 4 EXEC cycles; vd_addr 12,13,14,15; lane_mask 1111 each cycle; apu_rvalid on cycle 3 only.
- vl=6, vsew=1, vd=30 → 2 cycles; vd_addr 30 then 0 (wrap); lane_mask 1111 then 0011.
- vl=7, reduce_instr=1, vd=2, vs2=10 → vd 2,2; vs2 10,11; lane_mask 0000 then 0001.
- Three back-to-back reqs (vl=8, multi-cycle) → gnt drops after 2 accepted while the first executes; instructions run with no idle gap; 3 rvalid pulses at cycles 2,4,6 after the first grant.
- vl=0 multi-cycle → 1 EXEC cycle, lane_mask 0, rvalid pulse. Also: vl changes 16→4 mid-instruction → current instruction still runs 4 cycles.
- n_reset asserted during EXEC cycle 1 with 1 queued entry → busy=0, gnt=1, no rvalid, queue empty after release.
